// File: rtl/jr_hazard_ctrl_pkg.sv
// Shared MIPS control definitions: decode constants for register jumps and
// the jump-controller state encoding.
package jr_hazard_ctrl_pkg;

    // Main-decoder ALU op class for R-type instructions
    localparam logic [1:0] JR_ALUOP   = 2'b10;

    // R-type funct codes of the register jumps
    localparam logic [5:0] JR_FUNCT   = 6'h08;
    localparam logic [5:0] JALR_FUNCT = 6'h09;

    // Register that receives the return address of a JALR
    localparam int unsigned LINK_REG  = 31;

    // Jump controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_REDIRECT = 2'd2
    } jr_state_e;

    // Returns 1 when the low two bits of a jump target are nonzero
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/jr_operand_mux.sv
// Jump-source operand selection and EX/MEM hazard detection.
// r0 always reads as zero and never causes a hazard. A pending EX/MEM write
// to rs means the value does not exist anywhere yet, so it takes priority
// over a MEM/WB forward of an older value to the same register.
module jr_operand_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              busy_we,
    input  logic [REG_AW-1:0] busy_rd,
    input  logic              fwd_we,
    input  logic [REG_AW-1:0] fwd_rd,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] operand,
    output logic              hazard
);

    logic rs_is_zero;
    logic fwd_hit;

    // Pick r0 / forwarded / register-file value and flag an unresolved source
    always_comb begin
        rs_is_zero = (rs_addr == '0);
        hazard     = busy_we && (busy_rd == rs_addr) && !rs_is_zero;
        fwd_hit    = fwd_we && (fwd_rd == rs_addr);
        operand    = rs_data;
        if (rs_is_zero) begin
            operand = '0;
        end else if (hazard) begin
            operand = rs_data;
        end else if (fwd_hit) begin
            operand = fwd_data;
        end
    end

endmodule

// File: rtl/jr_hazard_ctrl.sv
// JR/JALR control for the ID stage: stalls while the jump source is still
// being produced, then redirects the PC for one cycle, flushing IF/ID and
// writing the return address for JALR. Misaligned targets and hazards that
// never resolve are recorded in sticky error flags.
module jr_hazard_ctrl
    import jr_hazard_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int FUNCT_W  = 6,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_id,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [REG_AW-1:0]  rs_addr,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  pc_plus4,
    input  logic               busy_we,
    input  logic [REG_AW-1:0]  busy_rd,
    input  logic               fwd_we,
    input  logic [REG_AW-1:0]  fwd_rd,
    input  logic [DATA_W-1:0]  fwd_data,
    output logic               stall,
    output logic               flush,
    output logic               pc_sel,
    output logic [DATA_W-1:0]  jr_target,
    output logic               link_we,
    output logic [DATA_W-1:0]  link_data,
    output logic               err_misalign,
    output logic               err_timeout
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    jr_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  target_q, target_d;
    logic [DATA_W-1:0]  link_data_q, link_data_d;
    logic               jalr_q, jalr_d;
    logic               err_misalign_q, err_misalign_d;
    logic               err_timeout_q, err_timeout_d;

    logic [DATA_W-1:0]  operand;
    logic               hazard;
    logic               funct_jr;
    logic               funct_jalr;
    logic               detect;

    jr_operand_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_operand_mux (
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .busy_we  (busy_we),
        .busy_rd  (busy_rd),
        .fwd_we   (fwd_we),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .operand  (operand),
        .hazard   (hazard)
    );

    // Decode a register jump in ID; the instruction behind a redirect is dead
    always_comb begin
        funct_jr   = (alu_op == JR_ALUOP) && (funct == FUNCT_W'(JR_FUNCT));
        funct_jalr = (alu_op == JR_ALUOP) && (funct == FUNCT_W'(JALR_FUNCT));
        detect     = valid_id && (funct_jr || funct_jalr) && (state_q != ST_REDIRECT);
    end

    // Next-state logic: capture the jump once its source is resolved
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        target_d       = target_q;
        link_data_d    = link_data_q;
        jalr_d         = jalr_q;
        err_misalign_d = err_misalign_q;
        err_timeout_d  = err_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    if (hazard) begin
                        state_d = ST_WAIT;
                        count_d = '0;
                    end else begin
                        state_d        = ST_REDIRECT;
                        target_d       = {operand[DATA_W-1:2], 2'b00};
                        err_misalign_d = err_misalign_q | is_misaligned(operand[1:0]);
                        jalr_d         = funct_jalr;
                        if (funct_jalr) begin
                            link_data_d = pc_plus4;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!hazard) begin
                    state_d        = ST_REDIRECT;
                    count_d        = '0;
                    target_d       = {operand[DATA_W-1:2], 2'b00};
                    err_misalign_d = err_misalign_q | is_misaligned(operand[1:0]);
                    jalr_d         = funct_jalr;
                    if (funct_jalr) begin
                        link_data_d = pc_plus4;
                    end
                end else if ((count_q + CNT_W'(1)) == CNT_W'(WAIT_MAX)) begin
                    state_d       = ST_IDLE;
                    count_d       = '0;
                    err_timeout_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            target_q       <= '0;
            link_data_q    <= '0;
            jalr_q         <= 1'b0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            target_q       <= target_d;
            link_data_q    <= link_data_d;
            jalr_q         <= jalr_d;
            err_misalign_q <= err_misalign_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    // Pipeline control from state and inputs, silenced while reset is high
    always_comb begin
        stall   = 1'b0;
        flush   = 1'b0;
        pc_sel  = 1'b0;
        link_we = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    stall = detect;
                end
                ST_WAIT: begin
                    stall = 1'b1;
                end
                ST_REDIRECT: begin
                    flush   = 1'b1;
                    pc_sel  = 1'b1;
                    link_we = jalr_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign jr_target    = target_q;
    assign link_data    = link_data_q;
    assign err_misalign = err_misalign_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_jr_hazard_ctrl.sv
// Directed bench for jr_hazard_ctrl: reset, non-jumps, JR, JALR, hazard
// wait with forwarding, timeout, misalignment, r0 source, reset during WAIT.
module tb_jr_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        valid_id;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic [31:0] pc_plus4;
    logic        busy_we;
    logic [4:0]  busy_rd;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        stall;
    logic        flush;
    logic        pc_sel;
    logic [31:0] jr_target;
    logic        link_we;
    logic [31:0] link_data;
    logic        err_misalign;
    logic        err_timeout;

    int checks;
    int errors;

    jr_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .valid_id     (valid_id),
        .alu_op       (alu_op),
        .funct        (funct),
        .rs_addr      (rs_addr),
        .rs_data      (rs_data),
        .pc_plus4     (pc_plus4),
        .busy_we      (busy_we),
        .busy_rd      (busy_rd),
        .fwd_we       (fwd_we),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .stall        (stall),
        .flush        (flush),
        .pc_sel       (pc_sel),
        .jr_target    (jr_target),
        .link_we      (link_we),
        .link_data    (link_data),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one ID-stage picture and let the combinational outputs settle
    task automatic applyStimulus(
        input logic        v,
        input logic [1:0]  op,
        input logic [5:0]  fn,
        input logic [4:0]  rs,
        input logic [31:0] rsd,
        input logic [31:0] pc4,
        input logic        bwe,
        input logic [4:0]  brd,
        input logic        fwe,
        input logic [4:0]  frd,
        input logic [31:0] fd
    );
        valid_id = v;
        alu_op   = op;
        funct    = fn;
        rs_addr  = rs;
        rs_data  = rsd;
        pc_plus4 = pc4;
        busy_we  = bwe;
        busy_rd  = brd;
        fwd_we   = fwe;
        fwd_rd   = frd;
        fwd_data = fd;
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Control outputs packed as {stall, flush, pc_sel, link_we}
    task automatic checkCtrl(input string tag, input logic [3:0] expected);
        checkOutput(tag, {28'h0, stall, flush, pc_sel, link_we}, {28'h0, expected});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idleInputs();
        repeat (2) nextCycle();

        // Reset state, with a JR presented while reset is still high
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd8, 32'h0040_0100, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("reset_ctrl_gated", 4'b0000);
        checkOutput("reset_target", jr_target, 32'h0);
        checkOutput("reset_link_data", link_data, 32'h0);
        checkOutput("reset_errs", {30'h0, err_misalign, err_timeout}, 32'h0);

        // Non-jump instructions leave everything quiet
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b1, 2'b10, 6'h20, 5'd8, 32'h0040_0100, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("nonjump_add", 4'b0000);
        nextCycle();
        applyStimulus(1'b1, 2'b00, 6'h08, 5'd8, 32'h0040_0100, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("nonjump_aluop", 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 2'b10, 6'h08, 5'd8, 32'h0040_0100, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("nonjump_invalid", 4'b0000);
        checkOutput("nonjump_target", jr_target, 32'h0);

        // Hazard-free JR: one stall cycle, then redirect
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd8, 32'h0040_0100, 32'h0040_0008, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("jr_stall", 4'b1000);
        nextCycle();
        checkCtrl("jr_redirect", 4'b0110);
        checkOutput("jr_target", jr_target, 32'h0040_0100);
        nextCycle();
        idleInputs();
        checkCtrl("jr_back_idle", 4'b0000);
        checkOutput("jr_target_held", jr_target, 32'h0040_0100);

        // JALR: redirect with return-address write
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h09, 5'd4, 32'h0040_0200, 32'h0040_0020, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("jalr_stall", 4'b1000);
        nextCycle();
        checkCtrl("jalr_redirect", 4'b0111);
        checkOutput("jalr_link_data", link_data, 32'h0040_0020);
        checkOutput("jalr_target", jr_target, 32'h0040_0200);
        nextCycle();
        idleInputs();
        checkCtrl("jalr_back_idle", 4'b0000);
        checkOutput("jalr_link_held", link_data, 32'h0040_0020);

        // JR r9 with a pending write for three cycles, then forwarded value
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd9, 32'hDEAD_0000, 32'h0040_0040, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        checkCtrl("hz_c1", 4'b1000);
        nextCycle();
        checkCtrl("hz_c2", 4'b1000);
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd9, 32'hDEAD_0000, 32'h0040_0040, 1'b1, 5'd9, 1'b1, 5'd9, 32'h2222);
        checkCtrl("hz_c3_busy_over_fwd", 4'b1000);
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd9, 32'hDEAD_0000, 32'h0040_0040, 1'b0, 5'd9, 1'b1, 5'd9, 32'h1000);
        checkCtrl("hz_c4", 4'b1000);
        nextCycle();
        checkCtrl("hz_c5_redirect", 4'b0110);
        checkOutput("hz_target", jr_target, 32'h1000);
        nextCycle();
        idleInputs();
        checkCtrl("hz_back_idle", 4'b0000);

        // Hazard never clears: 1 detect cycle + 15 wait cycles, then abort
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd10, 32'h0040_0300, 32'h0040_0060, 1'b1, 5'd10, 1'b0, 5'd0, 32'h0);
        checkCtrl("to_detect", 4'b1000);
        for (int i = 0; i < 15; i++) begin
            nextCycle();
            checkCtrl($sformatf("to_wait_%0d", i), 4'b1000);
            checkOutput($sformatf("to_flag_low_%0d", i), {31'h0, err_timeout}, 32'h0);
        end
        nextCycle();
        idleInputs();
        checkCtrl("to_idle", 4'b0000);
        checkOutput("to_flag_set", {31'h0, err_timeout}, 32'h1);
        checkOutput("to_target_unchanged", jr_target, 32'h1000);
        nextCycle();
        checkCtrl("to_stays_idle", 4'b0000);

        // Misaligned target is recorded and cleared to a word address
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd3, 32'h0040_0103, 32'h0040_0080, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkCtrl("mis_stall", 4'b1000);
        checkOutput("mis_flag_before", {31'h0, err_misalign}, 32'h0);
        nextCycle();
        checkCtrl("mis_redirect", 4'b0110);
        checkOutput("mis_target", jr_target, 32'h0040_0100);
        checkOutput("mis_flag", {31'h0, err_misalign}, 32'h1);
        nextCycle();
        idleInputs();

        // r0 source: busy/forward on r0 ignored, target is zero
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd0, 32'h1234_5678, 32'h0040_00A0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h55);
        checkCtrl("r0_stall", 4'b1000);
        nextCycle();
        checkCtrl("r0_redirect", 4'b0110);
        checkOutput("r0_target", jr_target, 32'h0);
        checkOutput("r0_flags_sticky", {30'h0, err_misalign, err_timeout}, 32'h3);
        nextCycle();
        idleInputs();

        // Reset in WAIT abandons the jump and clears the flags
        nextCycle();
        applyStimulus(1'b1, 2'b10, 6'h08, 5'd7, 32'h0040_0400, 32'h0040_00C0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        checkCtrl("rst_detect", 4'b1000);
        nextCycle();
        checkCtrl("rst_in_wait", 4'b1000);
        reset = 1'b1;
        #1;
        checkCtrl("rst_same_cycle", 4'b0000);
        nextCycle();
        reset = 1'b0;
        idleInputs();
        checkCtrl("rst_after_ctrl", 4'b0000);
        checkOutput("rst_after_target", jr_target, 32'h0);
        checkOutput("rst_after_link", link_data, 32'h0);
        checkOutput("rst_after_flags", {30'h0, err_misalign, err_timeout}, 32'h0);
        nextCycle();
        checkCtrl("rst_idle_hold", 4'b0000);

        $display("[TB] directed sequence complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jr_hazard_ctrl.md
JR_HAZARD_CTRL -- requirements
Module: jr_hazard_ctrl

Parameters
REQ-001 SHALL provide DATA_W, default 32, datapath and PC width.
REQ-002 SHALL provide REG_AW, default 5, register address width.
REQ-003 SHALL provide FUNCT_W, default 6, funct field width.
REQ-004 SHALL provide WAIT_MAX, default 15, maximum hazard-wait cycles before abort.

Interface
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 valid_id  in  1  ID-stage instruction valid.
REQ-008 alu_op  in  2  main-decoder ALU op class.
REQ-009 funct  in  FUNCT_W  R-type funct field.
REQ-010 rs_addr  in  REG_AW  jump source register.
REQ-011 rs_data  in  DATA_W  register-file read of rs.
REQ-012 pc_plus4  in  DATA_W  PC+4 of the ID instruction.
REQ-013 busy_we, busy_rd  in  1, REG_AW  EX/MEM write still pending (value not yet available).
REQ-014 fwd_we, fwd_rd, fwd_data  in  1, REG_AW, DATA_W  MEM/WB result available for forwarding.
REQ-015 stall  out  1  hold PC and IF/ID.
REQ-016 flush  out  1  clear IF/ID.
REQ-017 pc_sel  out  1  select jr_target as next PC.
REQ-018 jr_target  out  DATA_W  registered jump target.
REQ-019 link_we, link_data  out  1, DATA_W  JALR write of return address to r31.
REQ-020 err_misalign, err_timeout  out  1 each  sticky error flags.

Function
REQ-021 Detect: is_jr = valid_id & alu_op==JR_ALUOP & funct==JR_FUNCT; is_jalr same with JALR_FUNCT; detection ignored in REDIRECT.
REQ-022 Hazard = busy_we & busy_rd==rs_addr & rs_addr!=0.
REQ-023 Operand = 0 if rs_addr==0; else fwd_data if fwd_we & fwd_rd==rs_addr; else rs_data; a busy match overrides a fwd match (hazard).
REQ-024 FSM states IDLE, WAIT, REDIRECT; reset state IDLE.
REQ-025 IDLE: detect & no hazard -> capture target, jalr flag, pc_plus4; go REDIRECT; stall=1 this cycle.
REQ-026 IDLE: detect & hazard -> WAIT, clear wait counter, stall=1.
REQ-027 WAIT: stall=1, counter+1 per cycle; hazard clear -> capture operand, go REDIRECT.
REQ-028 WAIT: counter reaching WAIT_MAX with hazard still set -> set err_timeout, go IDLE, no redirect.
REQ-029 REDIRECT: pc_sel=1, flush=1, stall=0 for exactly one cycle; link_we=1 and link_data=captured pc_plus4 iff JALR; then IDLE.
REQ-030 Latency: hazard-free JR detected in cycle N -> pc_sel in cycle N+1; with k hazard cycles -> N+1+k.
REQ-031 Target low 2 bits nonzero -> set err_misalign; jr_target forced to operand with bits [1:0] cleared.
REQ-032 stall, flush, pc_sel, link_we combinational from state and inputs; jr_target and link_data registered and held outside REDIRECT.
REQ-033 Non-jump instructions: all control outputs 0, no state change.

Reset
REQ-034 reset SHALL force IDLE, counter 0, jr_target 0, link_data 0, both error flags 0, all control outputs 0 in the same cycle; reset during WAIT or REDIRECT abandons the jump.
REQ-035 Error flags SHALL clear only on reset.

Structure
REQ-036 JR_ALUOP (2'b10), JR_FUNCT (6'h08), JALR_FUNCT (6'h09), LINK_REG (31), and the state enumeration SHALL live in the shared mips control package.
REQ-037 Operand selection (REQ-023) SHALL be a sub-module jr_operand_mux; FSM and registers stay in jr_hazard_ctrl.

Verification
REQ-038 JR, rs=8, rs_data=0x0040_0100, no hazard -> stall 1 cycle, next cycle pc_sel=flush=1, jr_target=0x0040_0100, link_we=0.
REQ-039 JALR, pc_plus4=0x0040_0020, rs_data=0x0040_0200 -> REDIRECT with link_we=1, link_data=0x0040_0020.
REQ-040 JR rs=9, busy_rd=9 for 3 cycles, then fwd_rd=9 fwd_data=0x1000 -> stall 4 cycles, pc_sel on cycle 5, target 0x1000.
REQ-041 busy_rd=rs held 15 cycles -> err_timeout=1, back to IDLE, pc_sel never asserted.
REQ-042 rs_data=0x0040_0103 -> err_misalign=1, jr_target=0x0040_0100; rs=0 with busy_rd=0 -> no stall beyond 1 cycle, target 0.
REQ-043 reset asserted in WAIT -> next cycle all outputs 0, IDLE, flags cleared.
